// File: rtl/display_pkg.sv
// Shared constants and small helpers for the three-digit scan driver.
package display_pkg;

  // Active-low seven-segment patterns, bit 7 is dp (1 = dark), [6:0] = g..a.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;

  // Digit index values; DIG_OFF turns every digit off downstream.
  localparam logic [1:0] DIG0    = 2'd0;
  localparam logic [1:0] DIG1    = 2'd1;
  localparam logic [1:0] DIG2    = 2'd2;
  localparam logic [1:0] DIG_OFF = 2'b11;

  // Pick the BCD nibble belonging to a digit index.
  function automatic logic [3:0] digit_sel(input logic [11:0] bcd, input logic [1:0] idx);
    logic [3:0] d;
    case (idx)
      DIG0:    d = bcd[3:0];
      DIG1:    d = bcd[7:4];
      DIG2:    d = bcd[11:8];
      default: d = 4'h0;
    endcase
    return d;
  endfunction

  // Pick the decimal-point request belonging to a digit index.
  function automatic logic dp_sel(input logic [2:0] dp, input logic [1:0] idx);
    logic b;
    case (idx)
      DIG0:    b = dp[0];
      DIG1:    b = dp[1];
      DIG2:    b = dp[2];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/display_scan_if.sv
// Data/strobe bundle between the stopwatch core and the scan driver.
interface display_scan_if;
  logic [11:0] i_bcd;
  logic [2:0]  i_dp;
  logic        i_load;
  logic        i_blank_lz;
  logic [1:0]  o_refresh_counter;
  logic [7:0]  o_segments;
  logic        o_frame_tick;

  modport master (
    output i_bcd, i_dp, i_load, i_blank_lz,
    input  o_refresh_counter, o_segments, o_frame_tick
  );

  modport slave (
    input  i_bcd, i_dp, i_load, i_blank_lz,
    output o_refresh_counter, o_segments, o_frame_tick
  );
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder with blank and dp.
module bcd_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  logic [7:0] base_s;

  // Decode the nibble (dash for A-F), then let a lit dp clear bit 7 even on a blank digit.
  always_comb begin
    base_s = SEG_DASH;
    if (i_blank) begin
      base_s = SEG_BLANK;
    end else begin
      case (i_bcd)
        4'd0:    base_s = SEG_0;
        4'd1:    base_s = SEG_1;
        4'd2:    base_s = SEG_2;
        4'd3:    base_s = SEG_3;
        4'd4:    base_s = SEG_4;
        4'd5:    base_s = SEG_5;
        4'd6:    base_s = SEG_6;
        4'd7:    base_s = SEG_7;
        4'd8:    base_s = SEG_8;
        4'd9:    base_s = SEG_9;
        default: base_s = SEG_DASH;
      endcase
    end
    if (i_dp) begin
      o_seg = base_s & 8'h7F;
    end else begin
      o_seg = base_s;
    end
  end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed scan driver for a three-digit seven-segment display with
// double-buffered data that swaps only at frame boundaries.
module display_scan
  import display_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  display_scan_if.slave bus
);

  localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [11:0]   pend_bcd_q, pend_bcd_d;
  logic [2:0]    pend_dp_q, pend_dp_d;
  logic [11:0]   disp_bcd_q, disp_bcd_d;
  logic [2:0]    disp_dp_q, disp_dp_d;
  logic [7:0]    seg_q, seg_d;

  logic          tick_s;
  logic          boundary_s;
  logic [3:0]    sel_bcd_s;
  logic          sel_dp_s;
  logic          sel_blank_s;
  logic          blank2_s;
  logic          blank1_s;
  logic [7:0]    dec_seg_s;

  // Prescaler, digit index rotation and the two data buffers.
  always_comb begin
    tick_s     = (presc_q == PRESC_MAX);
    boundary_s = tick_s && ((idx_q == DIG2) || (idx_q == DIG_OFF));

    if (tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (tick_s) begin
      case (idx_q)
        DIG0:    idx_d = DIG1;
        DIG1:    idx_d = DIG2;
        default: idx_d = DIG0;
      endcase
    end else begin
      idx_d = idx_q;
    end

    // Display takes the old pending contents even when a load lands on the boundary.
    if (boundary_s) begin
      disp_bcd_d = pend_bcd_q;
      disp_dp_d  = pend_dp_q;
    end else begin
      disp_bcd_d = disp_bcd_q;
      disp_dp_d  = disp_dp_q;
    end

    if (bus.i_load) begin
      pend_bcd_d = bus.i_bcd;
      pend_dp_d  = bus.i_dp;
    end else begin
      pend_bcd_d = pend_bcd_q;
      pend_dp_d  = pend_dp_q;
    end
  end

  // Select the digit about to be shown, using post-swap data and live blanking.
  always_comb begin
    blank2_s  = bus.i_blank_lz && (disp_bcd_d[11:8] == 4'd0);
    blank1_s  = blank2_s && (disp_bcd_d[7:4] == 4'd0);
    sel_bcd_s = digit_sel(disp_bcd_d, idx_d);
    sel_dp_s  = dp_sel(disp_dp_d, idx_d);
    case (idx_d)
      DIG1:    sel_blank_s = blank1_s;
      DIG2:    sel_blank_s = blank2_s;
      default: sel_blank_s = 1'b0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .i_bcd   (sel_bcd_s),
    .i_blank (sel_blank_s),
    .i_dp    (sel_dp_s),
    .o_seg   (dec_seg_s)
  );

  // Segment pattern advances on the same edge as the index so they never disagree.
  always_comb begin
    if (tick_s) begin
      seg_d = dec_seg_s;
    end else begin
      seg_d = seg_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc_q    <= '0;
      idx_q      <= DIG_OFF;
      pend_bcd_q <= 12'h000;
      pend_dp_q  <= 3'b000;
      disp_bcd_q <= 12'h000;
      disp_dp_q  <= 3'b000;
      seg_q      <= SEG_BLANK;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      pend_bcd_q <= pend_bcd_d;
      pend_dp_q  <= pend_dp_d;
      disp_bcd_q <= disp_bcd_d;
      disp_dp_q  <= disp_dp_d;
      seg_q      <= seg_d;
    end
  end

  assign bus.o_refresh_counter = idx_q;
  assign bus.o_segments        = seg_q;
  // Frame pulse coincides with the swap cycle so a load in that cycle can be aligned to it.
  assign bus.o_frame_tick      = boundary_s & ~i_rst;

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan with TICK_DIV = 4.
module tb_display_scan;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst;

  display_scan_if bus ();

  display_scan #(.TICK_DIV(TD)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: m = clock edges since reset release.
  int          m;
  logic [11:0] pend_bcd, disp_bcd;
  logic [2:0]  pend_dp, disp_dp;
  logic [7:0]  exp_seg;
  logic [1:0]  exp_idx;
  logic [7:0]  seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int          ft_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (m=%0d)", tag, obs, exp, m);
    end
  endtask

  function automatic logic [7:0] exp_pattern(input int i);
    logic [3:0] d;
    logic       blank;
    logic [7:0] p;
    d     = disp_bcd[i*4 +: 4];
    blank = 1'b0;
    if (bus.i_blank_lz && i == 2 && disp_bcd[11:8] == 4'd0) blank = 1'b1;
    if (bus.i_blank_lz && i == 1 && disp_bcd[11:4] == 8'd0) blank = 1'b1;
    if (blank)        p = 8'hFF;
    else if (d < 10)  p = seg_tbl[d];
    else              p = 8'hBF;
    if (disp_dp[i]) p[7] = 1'b0;
    return p;
  endfunction

  // One clock edge: advance the model, then compare all outputs.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m        = 0;
      pend_bcd = 12'h000; pend_dp = 3'b000;
      disp_bcd = 12'h000; disp_dp = 3'b000;
      exp_idx  = 2'b11;   exp_seg = 8'hFF;
    end else begin
      if (m % 12 == 3) begin
        disp_bcd = pend_bcd;
        disp_dp  = pend_dp;
      end
      if (bus.i_load) begin
        pend_bcd = bus.i_bcd;
        pend_dp  = bus.i_dp;
      end
      m++;
      if (m % 4 == 0) begin
        exp_idx = 2'((m / 4 - 1) % 3);
        exp_seg = exp_pattern(int'(exp_idx));
      end
    end
    #1;
    chk("idx", 32'(bus.o_refresh_counter), 32'(exp_idx));
    chk("seg", 32'(bus.o_segments), 32'(exp_seg));
    chk("frame_tick", 32'(bus.o_frame_tick), 32'(!rst && (m % 12 == 3)));
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 2000 && m < target; k++) step();
    chk("run_to", 32'(m), 32'(target));
  endtask

  initial begin
    rst = 1'b1;
    bus.i_bcd = 12'h000; bus.i_dp = 3'b000; bus.i_load = 1'b0; bus.i_blank_lz = 1'b0;
    m = 0;

    // Reset and first frame
    step(); step(); step();
    chk("rst_idx", 32'(bus.o_refresh_counter), 32'h3);
    chk("rst_seg", 32'(bus.o_segments), 32'hFF);
    rst = 1'b0;
    run_to(3);
    chk("rst_hold_idx", 32'(bus.o_refresh_counter), 32'h3);
    chk("first_ft", 32'(bus.o_frame_tick), 32'h1);
    step();
    chk("first_idx0", 32'(bus.o_refresh_counter), 32'h0);
    chk("first_seg0", 32'(bus.o_segments), 32'hC0);

    // Load and swap mid-frame
    run_to(6);
    bus.i_bcd = 12'h123; bus.i_dp = 3'b010; bus.i_load = 1'b1;
    step();
    bus.i_load = 1'b0;
    run_to(8);  chk("cur_frame_d1", 32'(bus.o_segments), 32'hC0);
    run_to(16); chk("load_d0", 32'(bus.o_segments), 32'hB0);
    run_to(20); chk("load_d1_dp", 32'(bus.o_segments), 32'h24);
    run_to(24); chk("load_d2", 32'(bus.o_segments), 32'hF9);

    // Leading-zero blanking
    bus.i_bcd = 12'h007; bus.i_dp = 3'b000; bus.i_load = 1'b1; bus.i_blank_lz = 1'b1;
    step();
    bus.i_load = 1'b0;
    run_to(28); chk("lz_d0", 32'(bus.o_segments), 32'hF8);
    run_to(32); chk("lz_d1", 32'(bus.o_segments), 32'hFF);
    run_to(36); chk("lz_d2", 32'(bus.o_segments), 32'hFF);
    bus.i_blank_lz = 1'b0;
    run_to(40); chk("nolz_d0", 32'(bus.o_segments), 32'hF8);
    run_to(44); chk("nolz_d1", 32'(bus.o_segments), 32'hC0);
    run_to(48); chk("nolz_d2", 32'(bus.o_segments), 32'hC0);

    // Load coinciding with the boundary
    run_to(51);
    chk("bnd_ft", 32'(bus.o_frame_tick), 32'h1);
    bus.i_bcd = 12'h555; bus.i_load = 1'b1;
    step();
    bus.i_load = 1'b0;
    chk("bnd_old_d0", 32'(bus.o_segments), 32'hF8);
    run_to(56); chk("bnd_old_d1", 32'(bus.o_segments), 32'hC0);
    run_to(60); chk("bnd_old_d2", 32'(bus.o_segments), 32'hC0);
    run_to(64); chk("bnd_new_d0", 32'(bus.o_segments), 32'h92);
    run_to(68); chk("bnd_new_d1", 32'(bus.o_segments), 32'h92);
    run_to(72); chk("bnd_new_d2", 32'(bus.o_segments), 32'h92);

    // Invalid BCD, then reset while index is 1
    bus.i_bcd = 12'hA00; bus.i_load = 1'b1;
    step();
    bus.i_load = 1'b0;
    run_to(84); chk("dash_d2", 32'(bus.o_segments), 32'hBF);
    run_to(93); chk("mid_idx1", 32'(bus.o_refresh_counter), 32'h1);
    rst = 1'b1;
    step();
    chk("midrst_idx", 32'(bus.o_refresh_counter), 32'h3);
    chk("midrst_seg", 32'(bus.o_segments), 32'hFF);
    rst = 1'b0;
    run_to(4);  chk("clr_d0", 32'(bus.o_segments), 32'hC0);
    run_to(8);  chk("clr_d1", 32'(bus.o_segments), 32'hC0);
    run_to(12); chk("clr_d2", 32'(bus.o_segments), 32'hC0);

    // Rotation over 100 frames with random traffic
    ft_cnt = 0;
    for (int c = 0; c < 1200; c++) begin
      bus.i_bcd  = 12'($urandom);
      bus.i_dp   = 3'($urandom);
      bus.i_load = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) bus.i_blank_lz = ~bus.i_blank_lz;
      step();
      if (bus.o_frame_tick === 1'b1) ft_cnt++;
    end
    bus.i_load = 1'b0;
    chk("frame_ticks_100", 32'(ft_cnt), 32'd100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
